// File: rtl/scale_offset_pipe.sv
// scale_offset_pipe: streaming y = a*scale[ch] + offset[ch] over a valid/ready stream.
// Two register stages: S1 holds the product, S2 holds the offset sum and drives the outputs.
// Samples are tagged with a round-robin channel index.
// Optional macro SCALE_OFFSET_LOAD_EN adds cfg_* ports and a per-channel
// coefficient table. Without the macro, SCALE/OFFSET are constants.
module scale_offset_pipe #(
  parameter int A_WIDTH   = 4,
  parameter int OUT_WIDTH = A_WIDTH + 2,
  parameter int C_WIDTH   = 4,
  parameter int NUM_CH    = 1,
  parameter int SCALE     = 4,
  parameter int OFFSET    = 3,
  parameter int SATURATE  = 0,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_WIDTH-1:0]   in_a,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_y,
  output logic [CH_W-1:0]      out_ch
`ifdef SCALE_OFFSET_LOAD_EN
  ,
  input  logic                 cfg_we,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic [C_WIDTH-1:0]   cfg_scale,
  input  logic [C_WIDTH-1:0]   cfg_offset
`endif
);

  localparam int PW = A_WIDTH + C_WIDTH;
  localparam int SW = PW + 1;
  // Sum width is always kept wider than OUT_WIDTH, so the overflow slice is never empty.
  localparam int EW = ((SW > OUT_WIDTH) ? SW : OUT_WIDTH) + 1;

  logic                 adv1, adv2, accept;
  logic [CH_W-1:0]      ch_q, ch_d;
  logic [C_WIDTH-1:0]   scale_cur, off_cur, s1_off;
  logic                 s1_vld_q, s2_vld_q;
  logic [PW-1:0]        s1_prod_q, prod_d;
  logic [CH_W-1:0]      s1_ch_q, out_ch_q;
  logic [EW-1:0]        sum_ext;
  logic                 ovf;
  logic [OUT_WIDTH-1:0] y_d, out_y_q;

  // Each stage advances when the stage after it can take its contents.
  // in_ready depends combinationally on out_ready only, never on in_valid.
  assign adv2     = out_ready | ~s2_vld_q;
  assign adv1     = adv2 | ~s1_vld_q;
  assign in_ready = adv1;
  assign accept   = in_valid & adv1;

`ifdef SCALE_OFFSET_LOAD_EN
  logic [C_WIDTH-1:0] scale_q [NUM_CH];
  logic [C_WIDTH-1:0] offset_q [NUM_CH];
  logic [C_WIDTH-1:0] s1_off_q;

  // Coefficient table. A write to an index >= NUM_CH matches no entry and is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        scale_q[i]  <= C_WIDTH'(SCALE);
        offset_q[i] <= C_WIDTH'(OFFSET);
      end
    end else if (cfg_we) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg_ch == CH_W'(i)) begin
          scale_q[i]  <= cfg_scale;
          offset_q[i] <= cfg_offset;
        end
      end
    end
  end

  // Read the pair for the current channel. A same-cycle write is not yet visible.
  always_comb begin
    scale_cur = '0;
    off_cur   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_q == CH_W'(i)) begin
        scale_cur = scale_q[i];
        off_cur   = offset_q[i];
      end
    end
  end

  // Carry the offset seen at accept with the sample, so later writes cannot affect it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      s1_off_q <= '0;
    else if (accept) s1_off_q <= off_cur;
  end
  assign s1_off = s1_off_q;
`else
  assign scale_cur = C_WIDTH'(SCALE);
  assign off_cur   = C_WIDTH'(OFFSET);
  assign s1_off    = off_cur;
`endif

  assign ch_d   = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + CH_W'(1);
  assign prod_d = PW'(in_a) * PW'(scale_cur);

  // Round-robin channel tag. It advances only on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ch_q <= '0;
    else if (accept) ch_q <= ch_d;
  end

  // S1: full-width product. A bubble loads valid=0 when the stage advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_prod_q <= '0;
      s1_ch_q   <= '0;
    end else begin
      if (adv1) s1_vld_q <= accept;
      if (accept) begin
        s1_prod_q <= prod_d;
        s1_ch_q   <= ch_q;
      end
    end
  end

  // Full-precision sum, then either wrap (drop high bits) or clamp to all-ones.
  assign sum_ext = EW'(s1_prod_q) + EW'(s1_off);
  assign ovf     = |sum_ext[EW-1:OUT_WIDTH];
  assign y_d     = (SATURATE != 0 && ovf) ? '1 : sum_ext[OUT_WIDTH-1:0];

  // S2: output register. It holds while the consumer stalls it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld_q <= 1'b0;
      out_y_q  <= '0;
      out_ch_q <= '0;
    end else if (adv2) begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        out_y_q  <= y_d;
        out_ch_q <= s1_ch_q;
      end
    end
  end

  assign out_valid = s2_vld_q;
  assign out_y     = out_y_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_scale_offset_pipe.sv
// Directed bench for scale_offset_pipe. Four instances share one input stream:
// dA defaults, dB OFFSET=4 wrap, dC OFFSET=4 saturate, dD NUM_CH=3.
module tb_scale_offset_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, out_ready;
  logic [3:0] in_a;

  logic       rdyA, rdyB, rdyC, rdyD;
  logic       vA, vB, vC, vD;
  logic [5:0] yA, yB, yC, yD;
  logic [0:0] chA, chB, chC;
  logic [1:0] chD;

`ifdef SCALE_OFFSET_LOAD_EN
  logic       cfg_we;
  logic [1:0] cfg_ch;
  logic [3:0] cfg_scale, cfg_offset;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  scale_offset_pipe dA (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdyA), .in_a(in_a),
    .out_valid(vA), .out_ready(out_ready), .out_y(yA), .out_ch(chA)
`ifdef SCALE_OFFSET_LOAD_EN
    , .cfg_we(cfg_we), .cfg_ch(cfg_ch[0:0]), .cfg_scale(cfg_scale), .cfg_offset(cfg_offset)
`endif
  );

  scale_offset_pipe #(.OFFSET(4)) dB (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdyB), .in_a(in_a),
    .out_valid(vB), .out_ready(out_ready), .out_y(yB), .out_ch(chB)
`ifdef SCALE_OFFSET_LOAD_EN
    , .cfg_we(cfg_we), .cfg_ch(cfg_ch[0:0]), .cfg_scale(cfg_scale), .cfg_offset(cfg_offset)
`endif
  );

  scale_offset_pipe #(.OFFSET(4), .SATURATE(1)) dC (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdyC), .in_a(in_a),
    .out_valid(vC), .out_ready(out_ready), .out_y(yC), .out_ch(chC)
`ifdef SCALE_OFFSET_LOAD_EN
    , .cfg_we(cfg_we), .cfg_ch(cfg_ch[0:0]), .cfg_scale(cfg_scale), .cfg_offset(cfg_offset)
`endif
  );

  scale_offset_pipe #(.NUM_CH(3)) dD (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdyD), .in_a(in_a),
    .out_valid(vD), .out_ready(out_ready), .out_y(yD), .out_ch(chD)
`ifdef SCALE_OFFSET_LOAD_EN
    , .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_scale(cfg_scale), .cfg_offset(cfg_offset)
`endif
  );

  typedef struct {
    logic [3:0] a;
    logic [5:0] yA;   // a*4+3, also dD
    logic [5:0] yB;   // (a*4+4) mod 64
    logic [5:0] yC;   // min(a*4+4, 63)
    logic [1:0] ch;   // dD channel tag
  } vec_t;

  vec_t tv [7];

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tv[0] = '{a: 4'd5,  yA: 6'd23, yB: 6'd24, yC: 6'd24, ch: 2'd0};
    tv[1] = '{a: 4'd0,  yA: 6'd3,  yB: 6'd4,  yC: 6'd4,  ch: 2'd1};
    tv[2] = '{a: 4'd15, yA: 6'd63, yB: 6'd0,  yC: 6'd63, ch: 2'd2};
    tv[3] = '{a: 4'd14, yA: 6'd59, yB: 6'd60, yC: 6'd60, ch: 2'd0};
    tv[4] = '{a: 4'd1,  yA: 6'd7,  yB: 6'd8,  yC: 6'd8,  ch: 2'd1};
    tv[5] = '{a: 4'd10, yA: 6'd43, yB: 6'd44, yC: 6'd44, ch: 2'd2};
    tv[6] = '{a: 4'd7,  yA: 6'd31, yB: 6'd32, yC: 6'd32, ch: 2'd0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_a = '0;
`ifdef SCALE_OFFSET_LOAD_EN
    cfg_we = 1'b0; cfg_ch = '0; cfg_scale = '0; cfg_offset = '0;
`endif

    // Reset state
    #12;
    chk("rst_valid", int'(vA), 0);
    chk("rst_y", int'(yA), 0);
    chk("rst_ch", int'(chD), 0);
    chk("rst_ready", int'(rdyA), 1);
    rst_n = 1'b1;

    // Table: back-to-back stream; result i appears after the edge following its accept
    for (int t = 0; t <= 7; t++) begin
      in_valid = (t < 7);
      in_a     = (t < 7) ? tv[t].a : 4'd0;
      tick();
      if (t == 0) begin
        chk("tbl_fill_valid", int'(vA), 0);
      end else begin
        chk($sformatf("tbl%0d_vA", t - 1), int'(vA), 1);
        chk($sformatf("tbl%0d_vB", t - 1), int'(vB), 1);
        chk($sformatf("tbl%0d_vC", t - 1), int'(vC), 1);
        chk($sformatf("tbl%0d_vD", t - 1), int'(vD), 1);
        chk($sformatf("tbl%0d_yA", t - 1), int'(yA), int'(tv[t-1].yA));
        chk($sformatf("tbl%0d_yB_wrap", t - 1), int'(yB), int'(tv[t-1].yB));
        chk($sformatf("tbl%0d_yC_sat", t - 1), int'(yC), int'(tv[t-1].yC));
        chk($sformatf("tbl%0d_yD", t - 1), int'(yD), int'(tv[t-1].yA));
        chk($sformatf("tbl%0d_chD", t - 1), int'(chD), int'(tv[t-1].ch));
        chk($sformatf("tbl%0d_chABC", t - 1), int'(chA) + int'(chB) + int'(chC), 0);
        chk($sformatf("tbl%0d_rdy", t - 1), int'(rdyA), 1);
      end
    end
    tick();
    chk("tbl_drain_valid", int'(vA), 0);

    // Stall: out_ready low for 4 edges, 3 samples offered
    out_ready = 1'b0; in_valid = 1'b1; in_a = 4'd2;
    #1 chk("stall_rdy0", int'(rdyA), 1);
    tick();
    in_a = 4'd3;
    chk("stall_rdy1", int'(rdyA), 1);
    chk("stall_v1", int'(vA), 0);
    tick();
    chk("stall_v2", int'(vA), 1);
    chk("stall_y2", int'(yA), 11);
    in_a = 4'd4;
    chk("stall_rdy2", int'(rdyA), 0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk($sformatf("stall_hold%0d_y", k), int'(yA), 11);
      chk($sformatf("stall_hold%0d_v", k), int'(vA), 1);
      chk($sformatf("stall_hold%0d_rdy", k), int'(rdyA) + int'(rdyB) + int'(rdyC) + int'(rdyD), 0);
    end
    out_ready = 1'b1;
    #1 chk("stall_release_rdy", int'(rdyA), 1);
    tick();
    chk("stall_out0", int'(yA), 15);
    chk("stall_out0_v", int'(vA), 1);
    in_valid = 1'b0;
    tick();
    chk("stall_out1", int'(yA), 19);
    chk("stall_out1_v", int'(vA), 1);
    tick();
    chk("stall_done_v", int'(vA), 0);

    // Mid-stream reset: dD channel counter is nonzero, two samples in flight
    in_valid = 1'b1; in_a = 4'd1;
    repeat (3) tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_vA", int'(vA), 0);
    chk("mrst_vD", int'(vD), 0);
    chk("mrst_y", int'(yA), 0);
    chk("mrst_rdy", int'(rdyA), 1);
    tick();
    chk("mrst_hold_v", int'(vD), 0);
    rst_n = 1'b1;
    in_valid = 1'b1; in_a = 4'd6;
    tick();
    in_valid = 1'b0;
    chk("mrst_first_v0", int'(vD), 0);
    tick();
    chk("mrst_first_v", int'(vD), 1);
    chk("mrst_first_ch", int'(chD), 0);
    chk("mrst_first_y", int'(yD), 27);
    tick();
    chk("mrst_empty", int'(vD), 0);

`ifdef SCALE_OFFSET_LOAD_EN
    // Coefficient write to ch1 in the same cycle as a ch1 sample (dD next tag is 1)
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_scale = 4'd2; cfg_offset = 4'd1;
    in_valid = 1'b1; in_a = 4'd3;
    tick();
    cfg_we = 1'b0; in_a = 4'd0;
    tick();
    chk("cfg_same_y", int'(yD), 15);
    chk("cfg_same_ch", int'(chD), 1);
    in_a = 4'd0;
    tick();
    chk("cfg_ch2_y", int'(yD), 3);
    in_a = 4'd3;
    tick();
    chk("cfg_ch0_y", int'(yD), 3);
    in_valid = 1'b0;
    tick();
    chk("cfg_new_y", int'(yD), 7);
    chk("cfg_new_ch", int'(chD), 1);
    chk("cfg_ignored_A", int'(yA), 15);
    tick();
    chk("cfg_empty", int'(vD), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
